// File: rtl/set_assoc_cache.sv
// Blocking write-back, write-allocate set-associative data cache with LRU replacement and its own main-memory model.
// Latency: hits complete in the same cycle; a miss stalls for MEM_LAT+2 cycles (clean victim) or 2*MEM_LAT+2 (dirty victim).
// Backpressure: miss stalls the requester, which holds addr/req/data until miss falls.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   addr     byte address (word index, set and tag fields; low two bits ignored)
//   rd_req   read request, held until miss is low
//   rd_data  word of the hitting line, 0 when there is no hit
//   wr_req   write request, held until miss is low (wins over rd_req)
//   wr_data  word to write
//   miss     request cannot be serviced this cycle
module set_assoc_cache #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int SET_ADDR_LEN  = 2,
  parameter int TAG_ADDR_LEN  = 7,
  parameter int WAY_CNT       = 3,
  parameter int MEM_LAT       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        rd_req,
  output logic [31:0] rd_data,
  input  logic        wr_req,
  input  logic [31:0] wr_data,
  output logic        miss
);

  localparam int WORDS     = 1 << LINE_ADDR_LEN;
  localparam int SETS      = 1 << SET_ADDR_LEN;
  localparam int LINE_W    = 32 * WORDS;
  localparam int MEM_LINES = 1 << (TAG_ADDR_LEN + SET_ADDR_LEN);
  localparam int ADDR_HI   = LINE_ADDR_LEN + SET_ADDR_LEN + TAG_ADDR_LEN + 2;
  localparam int WAY_W     = (WAY_CNT > 1) ? $clog2(WAY_CNT) : 1;
  localparam int AGE_W     = WAY_W;
  localparam int CNT_W     = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(WAY_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {IDLE, SWAP_OUT, SWAP_IN, SWAP_IN_OK} state_t;

  // Address fields
  logic [LINE_ADDR_LEN-1:0] word_idx;
  logic [SET_ADDR_LEN-1:0]  set_idx;
  logic [TAG_ADDR_LEN-1:0]  tag;
  logic                     unused_addr;

  assign word_idx    = addr[LINE_ADDR_LEN+1:2];
  assign set_idx     = addr[LINE_ADDR_LEN+SET_ADDR_LEN+1 -: SET_ADDR_LEN];
  assign tag         = addr[ADDR_HI-1 -: TAG_ADDR_LEN];
  assign unused_addr = ^{addr[1:0], addr[31:ADDR_HI]};

  // Cache and memory storage
  logic [SETS-1:0][WAY_CNT-1:0] valid_q;
  logic [SETS-1:0][WAY_CNT-1:0] dirty_q;
  logic [TAG_ADDR_LEN-1:0]      tag_q  [SETS][WAY_CNT];
  logic [AGE_W-1:0]             age_q  [SETS][WAY_CNT];
  logic [LINE_W-1:0]            data_q [SETS][WAY_CNT];
  // Main-memory image: zero at power-up, never touched by reset.
  logic [LINE_W-1:0]            mem    [MEM_LINES];

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q;
  logic [SET_ADDR_LEN-1:0] miss_set_q;
  logic [TAG_ADDR_LEN-1:0] miss_tag_q;
  logic [WAY_W-1:0]        victim_q;

  // Lookup
  logic             req, hit_any, hit;
  logic [WAY_W-1:0] hit_way;
  logic [LINE_W-1:0] hit_line;

  assign req = rd_req | wr_req;

  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAY_CNT; w++) begin
      if (valid_q[set_idx][w] && (tag_q[set_idx][w] == tag)) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  assign hit      = (state_q == IDLE) && hit_any;
  assign hit_line = data_q[set_idx][hit_way];
  assign miss     = rst & req & ~hit;
  assign rd_data  = (rst && hit) ? hit_line[word_idx*32 +: 32] : 32'h0;

  // Victim: lowest-index invalid way, else the oldest way (lowest index on ties).
  logic             found_inv;
  logic [WAY_W-1:0] victim;
  logic [AGE_W-1:0] max_age;

  always_comb begin
    found_inv = 1'b0;
    victim    = '0;
    max_age   = age_q[set_idx][0];
    for (int w = 0; w < WAY_CNT; w++) begin
      if (!valid_q[set_idx][w] && !found_inv) begin
        found_inv = 1'b1;
        victim    = WAY_W'(w);
      end
    end
    if (!found_inv) begin
      for (int w = 0; w < WAY_CNT; w++) begin
        if (age_q[set_idx][w] > max_age) begin
          max_age = age_q[set_idx][w];
          victim  = WAY_W'(w);
        end
      end
    end
  end

  // LRU aging. A way being filled from the invalid state is treated as the
  // oldest, so the ages of a set converge to a permutation as it fills up
  // even though reset clears every age to zero.
  logic                    touch_en;
  logic [SET_ADDR_LEN-1:0] touch_set;
  logic [WAY_W-1:0]        touch_way;
  logic [AGE_W-1:0]        old_age;
  logic [AGE_W-1:0]        new_age [WAY_CNT];

  always_comb begin
    touch_en  = 1'b0;
    touch_set = set_idx;
    touch_way = hit_way;
    if (hit && req) begin
      touch_en = 1'b1;
    end else if (state_q == SWAP_IN_OK) begin
      touch_en  = 1'b1;
      touch_set = miss_set_q;
      touch_way = victim_q;
    end
    old_age = valid_q[touch_set][touch_way] ? age_q[touch_set][touch_way] : AGE_MAX;
    for (int w = 0; w < WAY_CNT; w++) begin
      new_age[w] = age_q[touch_set][w];
      if (WAY_W'(w) == touch_way) begin
        new_age[w] = '0;
      end else if (age_q[touch_set][w] < old_age) begin
        // Bounded by old_age, so it never passes AGE_MAX.
        new_age[w] = age_q[touch_set][w] + 1'b1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req && !hit_any) begin
          state_d = (valid_q[set_idx][victim] && dirty_q[set_idx][victim]) ? SWAP_OUT : SWAP_IN;
        end
      end
      SWAP_OUT:   if (cnt_q == '0) state_d = SWAP_IN;
      SWAP_IN:    if (cnt_q == '0) state_d = SWAP_IN_OK;
      SWAP_IN_OK: state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Control, tags, status bits and ages
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      miss_set_q <= '0;
      miss_tag_q <= '0;
      victim_q   <= '0;
      valid_q    <= '0;
      dirty_q    <= '0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAY_CNT; w++) begin
          tag_q[s][w] <= '0;
          age_q[s][w] <= '0;
        end
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (req && !hit_any) begin
            cnt_q      <= CNT_LOAD;
            miss_set_q <= set_idx;
            miss_tag_q <= tag;
            victim_q   <= victim;
          end
        end
        SWAP_OUT: cnt_q <= (cnt_q == '0) ? CNT_LOAD : cnt_q - 1'b1;
        SWAP_IN:  if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase

      if (hit && wr_req) begin
        dirty_q[set_idx][hit_way] <= 1'b1;
      end

      if (state_q == SWAP_IN_OK) begin
        valid_q[miss_set_q][victim_q] <= 1'b1;
        dirty_q[miss_set_q][victim_q] <= 1'b0;
        tag_q[miss_set_q][victim_q]   <= miss_tag_q;
      end

      if (touch_en) begin
        for (int w = 0; w < WAY_CNT; w++) begin
          age_q[touch_set][w] <= new_age[w];
        end
      end
    end
  end

  // Line data: word writes on hit, whole-line install at the end of a refill.
  always_ff @(posedge clk) begin
    if (hit && wr_req) begin
      data_q[set_idx][hit_way][word_idx*32 +: 32] <= wr_data;
    end
    if (state_q == SWAP_IN_OK) begin
      data_q[miss_set_q][victim_q] <= mem[{miss_tag_q, miss_set_q}];
    end
  end

  // Write-back lands on the last SWAP_OUT cycle; a reset before then loses it.
  always_ff @(posedge clk) begin
    if ((state_q == SWAP_OUT) && (cnt_q == '0)) begin
      mem[{tag_q[miss_set_q][victim_q], miss_set_q}] <= data_q[miss_set_q][victim_q];
    end
  end

endmodule

// File: tb/tb_set_assoc_cache.sv
module tb_set_assoc_cache;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic        rd_req;
  logic [31:0] rd_data;
  logic        wr_req;
  logic [31:0] wr_data;
  logic        miss;

  set_assoc_cache #(
    .LINE_ADDR_LEN(3),
    .SET_ADDR_LEN (2),
    .TAG_ADDR_LEN (7),
    .WAY_CNT      (3),
    .MEM_LAT      (8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .addr   (addr),
    .rd_req (rd_req),
    .rd_data(rd_data),
    .wr_req (wr_req),
    .wr_data(wr_data),
    .miss   (miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic [31:0] wd;
    int          exp_cyc;
    logic [31:0] exp_rd;
    string       name;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic add(input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] wd, input int cyc, input logic [31:0] exp_rd,
                     input string name);
    vec_t v;
    v.rd = rd; v.wr = wr; v.a = a; v.wd = wd;
    v.exp_cyc = cyc; v.exp_rd = exp_rd; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drives a request right after a rising edge, counts miss cycles at falling
  // edges, samples rd_data in the hit cycle, then drops the request after the
  // edge that completes the access.
  task automatic do_access(input logic r, input logic w, input logic [31:0] a,
                           input logic [31:0] d, output int cyc, output logic [31:0] rdat);
    rd_req = r; wr_req = w; addr = a; wr_data = d;
    cyc = 0;
    @(negedge clk);
    while (miss && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    rdat = rd_data;
    @(posedge clk); #1;
    rd_req = 1'b0; wr_req = 1'b0;
  endtask

  initial begin
    int          cyc;
    logic [31:0] rdat;

    rst = 1'b0; rd_req = 1'b0; wr_req = 1'b0; addr = '0; wr_data = '0;

    // Set 2 holds 0x40-line; set 0 holds 0x000/0x080/0x100/0x180 lines.
    add(1, 0, 32'h040, 32'h0,          10, 32'h0,          "cold_read_40");
    add(1, 0, 32'h040, 32'h0,           0, 32'h0,          "reread_40");
    add(0, 1, 32'h044, 32'h1234_5678,   0, 32'h0,          "write_hit_44");
    add(1, 0, 32'h044, 32'h0,           0, 32'h1234_5678,  "read_back_44");
    add(1, 0, 32'h000, 32'h0,          10, 32'h0,          "fill_000");
    add(1, 0, 32'h080, 32'h0,          10, 32'h0,          "fill_080");
    add(1, 0, 32'h100, 32'h0,          10, 32'h0,          "fill_100");
    add(1, 0, 32'h000, 32'h0,           0, 32'h0,          "touch_000");
    add(1, 0, 32'h180, 32'h0,          10, 32'h0,          "evict_lru_180");
    add(1, 0, 32'h000, 32'h0,           0, 32'h0,          "still_hit_000");
    add(1, 0, 32'h0C0, 32'h0,          10, 32'h0,          "conflict_0c0");
    add(1, 0, 32'h140, 32'h0,          10, 32'h0,          "conflict_140");
    add(1, 0, 32'h1C0, 32'h0,          18, 32'h0,          "dirty_evict_1c0");
    add(1, 0, 32'h044, 32'h0,          10, 32'h1234_5678,  "writeback_44");
    add(1, 1, 32'h044, 32'hA5A5_A5A5,   0, 32'h1234_5678,  "rdwr_old_44");
    add(1, 0, 32'h044, 32'h0,           0, 32'hA5A5_A5A5,  "rdwr_new_44");

    // Outputs are forced low while reset is held, even with a request up.
    repeat (2) @(posedge clk); #1;
    rd_req = 1'b1; addr = 32'h040;
    #1;
    check("reset_miss", {31'b0, miss}, 32'h0);
    check("reset_rd_data", rd_data, 32'h0);
    rd_req = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      do_access(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].wd, cyc, rdat);
      check({vecs[i].name, "_cycles"}, 32'(cyc), 32'(vecs[i].exp_cyc));
      check({vecs[i].name, "_data"}, rdat, vecs[i].exp_rd);
    end

    // 0x080 was evicted: one miss cycle, then drop the request; the refill
    // still completes and the line is resident afterwards.
    rd_req = 1'b1; addr = 32'h080;
    @(negedge clk);
    check("drop_req_miss", {31'b0, miss}, 32'h1);
    @(posedge clk); #1;
    rd_req = 1'b0;
    repeat (20) @(posedge clk); #1;
    do_access(1, 0, 32'h080, 32'h0, cyc, rdat);
    check("drop_req_installed_cycles", 32'(cyc), 32'h0);
    check("drop_req_installed_data", rdat, 32'h0);

    // Reset three cycles into a refill of 0x100.
    rd_req = 1'b1; addr = 32'h100;
    repeat (3) @(negedge clk);
    check("pre_abort_miss", {31'b0, miss}, 32'h1);
    rst = 1'b0;
    #1;
    check("abort_miss", {31'b0, miss}, 32'h0);
    check("abort_rd_data", rd_data, 32'h0);
    rd_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    do_access(1, 0, 32'h100, 32'h0, cyc, rdat);
    check("post_reset_100_cycles", 32'(cyc), 32'd10);
    check("post_reset_100_data", rdat, 32'h0);
    // Memory survives reset; the un-written-back 0xA5A5A5A5 is lost.
    do_access(1, 0, 32'h044, 32'h0, cyc, rdat);
    check("post_reset_44_cycles", 32'(cyc), 32'd10);
    check("post_reset_44_data", rdat, 32'h1234_5678);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
